// File: rtl/mcu_bus_if.sv
// 8051 external-memory bus to internal register-bus bridge.
// Synchronises the 8051 strobes, decodes the CPLD page and issues register read/write strobes.
module mcu_bus_if #(
    parameter logic [7:0] CS_PAGE = 8'h80,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_n_i,
    input  logic       ale_i,
    input  logic       rd_n_i,
    input  logic       wr_n_i,
    input  logic [7:0] p0_ad_i8,
    input  logic [7:0] p2_a_i8,
    output logic [7:0] p0_ad_o8,
    output logic       p0_ad_oe_o,
    output logic       mcu_rst_o,
    output logic       mcu_cs_o,
    output logic       mcu_rd_o,
    output logic       mcu_wr_o,
    output logic [7:0] mcu_addr_o8,
    output logic [7:0] mcu_wrdat_o8,
    input  logic [7:0] mcu_rddat_i8,
    output logic       bus_err_o
);

    typedef enum logic [2:0] {StIdle, StAddr, StWait, StRead, StWrite} state_e;

    logic       ale_s1_q, ale_s2_q;
    logic       rd_n_s1_q, rd_n_s2_q;
    logic       wr_n_s1_q, wr_n_s2_q;
    logic       rst_s1_q, mcu_rst_q;
    logic [7:0] addr_stg_q, addr_stg_d;
    logic [7:0] page_stg_q, page_stg_d;
    logic [7:0] dat_stg_q, dat_stg_d;
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       hit_q, hit_d;
    logic       wr_pend_q, wr_pend_d;
    logic       cs_q, cs_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
    logic       err_q, err_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wrdat_q, wrdat_d;
    logic [7:0] p0_q, p0_d;

    // Register-file reset: asserted asynchronously, released through two flops.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            rst_s1_q  <= 1'b1;
            mcu_rst_q <= 1'b1;
        end else begin
            rst_s1_q  <= 1'b0;
            mcu_rst_q <= rst_s1_q;
        end
    end

    always_comb begin
        addr_stg_d = ale_s1_q ? p0_ad_i8 : addr_stg_q;
        page_stg_d = ale_s1_q ? p2_a_i8 : page_stg_q;
        dat_stg_d  = wr_n_s1_q ? dat_stg_q : p0_ad_i8;

        state_d   = state_q;
        cnt_d     = cnt_q;
        hit_d     = hit_q;
        wr_pend_d = 1'b0;
        err_d     = 1'b0;
        addr_d    = addr_q;
        wrdat_d   = wrdat_q;
        p0_d      = p0_q;

        unique case (state_q)
            StIdle: begin
                if (ale_s2_q) state_d = StAddr;
            end
            StAddr: begin
                if (!ale_s2_q) begin
                    state_d = StWait;
                    cnt_d   = 8'd0;
                    addr_d  = addr_stg_q;
                    hit_d   = (page_stg_q == CS_PAGE);
                end
            end
            StWait: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == TIMEOUT || (!rd_n_s2_q && !wr_n_s2_q)) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (ale_s2_q) begin
                    state_d = StAddr;
                end else if (!rd_n_s2_q) begin
                    state_d = StRead;
                end else if (!wr_n_s2_q) begin
                    state_d = StWrite;
                end
            end
            StRead: begin
                cnt_d = cnt_q + 8'd1;
                p0_d  = mcu_rddat_i8;
                if (cnt_q == TIMEOUT) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (rd_n_s2_q) begin
                    state_d = StIdle;
                end
            end
            StWrite: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == TIMEOUT) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (wr_n_s2_q) begin
                    state_d   = StIdle;
                    wrdat_d   = dat_stg_q;
                    wr_pend_d = hit_q;
                end
            end
            default: state_d = StIdle;
        endcase

        // Write strobe lands one cycle after completion so address and data are already settled.
        rd_d = (state_d == StRead) && hit_d;
        wr_d = wr_pend_q;
        cs_d = rd_d || wr_pend_q;
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            ale_s1_q   <= 1'b0;
            ale_s2_q   <= 1'b0;
            rd_n_s1_q  <= 1'b1;
            rd_n_s2_q  <= 1'b1;
            wr_n_s1_q  <= 1'b1;
            wr_n_s2_q  <= 1'b1;
            addr_stg_q <= 8'h00;
            page_stg_q <= 8'h00;
            dat_stg_q  <= 8'h00;
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            hit_q      <= 1'b0;
            wr_pend_q  <= 1'b0;
            cs_q       <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= 8'h00;
            wrdat_q    <= 8'h00;
            p0_q       <= 8'h00;
        end else begin
            ale_s1_q   <= ale_i;
            ale_s2_q   <= ale_s1_q;
            rd_n_s1_q  <= rd_n_i;
            rd_n_s2_q  <= rd_n_s1_q;
            wr_n_s1_q  <= wr_n_i;
            wr_n_s2_q  <= wr_n_s1_q;
            addr_stg_q <= addr_stg_d;
            page_stg_q <= page_stg_d;
            dat_stg_q  <= dat_stg_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hit_q      <= hit_d;
            wr_pend_q  <= wr_pend_d;
            cs_q       <= cs_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wrdat_q    <= wrdat_d;
            p0_q       <= p0_d;
        end
    end

    // OE follows the raw pin so the driver releases P0 as soon as /RD rises.
    assign p0_ad_oe_o   = (state_q == StRead) && hit_q && !rd_n_i;
    assign p0_ad_o8     = p0_q;
    assign mcu_rst_o    = mcu_rst_q;
    assign mcu_cs_o     = cs_q;
    assign mcu_rd_o     = rd_q;
    assign mcu_wr_o     = wr_q;
    assign mcu_addr_o8  = addr_q;
    assign mcu_wrdat_o8 = wrdat_q;
    assign bus_err_o    = err_q;

endmodule

// File: tb/tb_mcu_bus_if.sv
// Directed bench for mcu_bus_if: 8051 read/write cycles, page miss, timeout, bus error, reset.
module tb_mcu_bus_if;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ale = 1'b0, rd_n = 1'b1, wr_n = 1'b1;
    logic [7:0] p0_i = 8'h00, p2 = 8'h00, rddat = 8'h00;
    logic [7:0] p0_o, addr_o, wrdat_o;
    logic       oe, mrst, cs, rd, wr, err;

    int n_checks = 0, n_errors = 0;
    int wr_cnt = 0, cs_cnt = 0, err_cnt = 0, oe_cnt = 0;
    int wr0, cs0, err0, oe0;

    mcu_bus_if dut (
        .sys_clk_i    (clk),
        .sys_rst_n_i  (rst_n),
        .ale_i        (ale),
        .rd_n_i       (rd_n),
        .wr_n_i       (wr_n),
        .p0_ad_i8     (p0_i),
        .p2_a_i8      (p2),
        .p0_ad_o8     (p0_o),
        .p0_ad_oe_o   (oe),
        .mcu_rst_o    (mrst),
        .mcu_cs_o     (cs),
        .mcu_rd_o     (rd),
        .mcu_wr_o     (wr),
        .mcu_addr_o8  (addr_o),
        .mcu_wrdat_o8 (wrdat_o),
        .mcu_rddat_i8 (rddat),
        .bus_err_o    (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr) wr_cnt++;
        if (cs) cs_cnt++;
        if (err) err_cnt++;
        if (oe) oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        wr0 = wr_cnt; cs0 = cs_cnt; err0 = err_cnt; oe0 = oe_cnt;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_p0"}, p0_o, 8'h00);
        check({pfx, "_oe"}, oe, 0);
        check({pfx, "_mrst"}, mrst, 1);
        check({pfx, "_cs"}, cs, 0);
        check({pfx, "_rd"}, rd, 0);
        check({pfx, "_wr"}, wr, 0);
        check({pfx, "_addr"}, addr_o, 8'h00);
        check({pfx, "_wrdat"}, wrdat_o, 8'h00);
        check({pfx, "_err"}, err, 0);
    endtask

    task automatic ale_phase(input logic [7:0] page, input logic [7:0] a);
        p2 = page; p0_i = a; ale = 1'b1;
        tick(3);
        ale = 1'b0;
        tick(3);
        check("addr_lat", addr_o, {24'd0, a});
    endtask

    task automatic bus_write(input logic [7:0] page, input logic [7:0] a, input logic [7:0] d,
                             input logic hit);
        ale_phase(page, a);
        p0_i = d; wr_n = 1'b0;
        tick(4);
        wr_n = 1'b1;
        tick(3);
        check("wr_early", wr, 0);
        tick(1);
        check("wr_pulse", wr, hit);
        check("wr_cs", cs, hit);
        check("wr_data", wrdat_o, d);
        check("wr_addr_hold", addr_o, a);
        tick(1);
        check("wr_width", wr, 0);
        tick(3);
    endtask

    task automatic bus_read(input logic [7:0] page, input logic [7:0] a, input logic [7:0] d,
                            input logic hit, input int hold);
        rddat = d;
        ale_phase(page, a);
        rd_n = 1'b0;
        tick(2);
        check("rd_early", rd, 0);
        tick(1);
        check("rd_lat", rd, hit);
        check("rd_cs", cs, hit);
        tick(1);
        if (hit) check("rd_p0", p0_o, d);
        check("rd_oe", oe, hit);
        tick(hold - 4);
        check("rd_oe_hold", oe, hit);
        check("rd_hold", rd, hit);
        rd_n = 1'b1;
        #1;
        check("rd_oe_drop", oe, 0);
        tick(2);
        check("rd_tail", rd, hit);
        tick(1);
        check("rd_end", rd, 0);
        tick(3);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("rst");
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("rst_rel1", mrst, 1);
        tick(1);
        check("rst_rel2", mrst, 0);
        tick(2);

        // Hit write
        snap();
        bus_write(8'h80, 8'h02, 8'hA5, 1'b1);
        check("w1_count", wr_cnt - wr0, 1);
        check("w1_cs_count", cs_cnt - cs0, 1);
        check("w1_err", err_cnt - err0, 0);

        // Hit read held 30 clocks
        snap();
        bus_read(8'h80, 8'h00, 8'h55, 1'b1, 30);
        check("r1_err", err_cnt - err0, 0);

        // Page miss write and read
        snap();
        bus_write(8'h40, 8'h03, 8'hAA, 1'b0);
        bus_read(8'h40, 8'h04, 8'h66, 1'b0, 12);
        check("miss_cs", cs_cnt - cs0, 0);
        check("miss_wr", wr_cnt - wr0, 0);
        check("miss_oe", oe_cnt - oe0, 0);

        // Timeout with /RD held low
        snap();
        rddat = 8'h55;
        ale_phase(8'h80, 8'h01);
        rd_n = 1'b0;
        tick(250);
        check("to_early", err_cnt - err0, 0);
        check("to_oe_live", oe, 1);
        tick(50);
        check("to_err", err_cnt - err0, 1);
        check("to_oe", oe, 0);
        check("to_rd", rd, 0);
        rd_n = 1'b1;
        tick(5);
        snap();
        bus_write(8'h80, 8'h07, 8'h3C, 1'b1);
        check("to_next_wr", wr_cnt - wr0, 1);

        // /RD and /WR both low
        snap();
        ale_phase(8'h80, 8'h05);
        rd_n = 1'b0; wr_n = 1'b0;
        tick(6);
        check("both_err", err_cnt - err0, 1);
        rd_n = 1'b1; wr_n = 1'b1;
        tick(8);
        check("both_wr", wr_cnt - wr0, 0);
        check("both_cs", cs_cnt - cs0, 0);

        // Code fetch: ALE only
        snap();
        ale_phase(8'h80, 8'h33);
        tick(10);
        check("fetch_cs", cs_cnt - cs0, 0);
        check("fetch_wr", wr_cnt - wr0, 0);

        // Reset mid-WRITE
        snap();
        ale_phase(8'h80, 8'h09);
        p0_i = 8'h77; wr_n = 1'b0;
        tick(5);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid");
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("mid_rel1", mrst, 1);
        tick(1);
        check("mid_rel2", mrst, 0);
        wr_n = 1'b1;
        tick(10);
        check("mid_no_wr", wr_cnt - wr0, 0);
        check("mid_wrdat", wrdat_o, 8'h00);

        snap();
        bus_write(8'h80, 8'h0A, 8'h5A, 1'b1);
        check("post_wr", wr_cnt - wr0, 1);
        check("post_err", err_cnt - err0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
